// File: rtl/led_pkg.sv
// Shared types and default 100 MHz timing for the WS2812 strand driver.
package led_pkg;

    localparam int DEF_COLOR_WIDTH  = 8;
    localparam int DEF_T0H_CYCLES   = 40;
    localparam int DEF_T0L_CYCLES   = 85;
    localparam int DEF_T1H_CYCLES   = 80;
    localparam int DEF_T1L_CYCLES   = 45;
    localparam int DEF_RESET_CYCLES = 8000;

    typedef struct packed {
        logic [DEF_COLOR_WIDTH-1:0] g;
        logic [DEF_COLOR_WIDTH-1:0] r;
        logic [DEF_COLOR_WIDTH-1:0] b;
    } grb_t;

    typedef enum logic [1:0] {
        LATCH,
        PRIME,
        SEND
    } drv_state_t;

    // Width able to count 0..max-1 for the longest of the timing intervals.
    function automatic int counter_width(input int t0h, input int t0l, input int t1h,
                                         input int t1l, input int rst_cycles);
        int m;
        m = t0h;
        if (t0l > m) m = t0l;
        if (t1h > m) m = t1h;
        if (t1l > m) m = t1l;
        if (rst_cycles > m) m = rst_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// One NRZ bit: line high for TxH cycles then low for TxL cycles; bit_done marks the final low cycle.
module ws2812_bit_encoder #(
    parameter int CNT_WIDTH  = 13,
    parameter int T0H_CYCLES = 40,
    parameter int T0L_CYCLES = 85,
    parameter int T1H_CYCLES = 80,
    parameter int T1L_CYCLES = 45
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_bit,
    output logic o_line,
    output logic o_bit_done
);

    logic                 r_active;
    logic                 r_high;
    logic                 r_bit;
    logic                 r_line;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_high_last;
    logic [CNT_WIDTH-1:0] w_low_last;

    assign w_high_last = r_bit ? CNT_WIDTH'(T1H_CYCLES - 1) : CNT_WIDTH'(T0H_CYCLES - 1);
    assign w_low_last  = r_bit ? CNT_WIDTH'(T1L_CYCLES - 1) : CNT_WIDTH'(T0L_CYCLES - 1);
    assign o_bit_done  = r_active && !r_high && (r_cnt == w_low_last);
    assign o_line      = r_line;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active <= 1'b0;
            r_high   <= 1'b0;
            r_bit    <= 1'b0;
            r_line   <= 1'b0;
            r_cnt    <= '0;
        end else if (i_start) begin
            // A new bit may start on the same edge the previous one finishes.
            r_active <= 1'b1;
            r_high   <= 1'b1;
            r_bit    <= i_bit;
            r_line   <= 1'b1;
            r_cnt    <= '0;
        end else if (r_active) begin
            if (r_high) begin
                if (r_cnt == w_high_last) begin
                    r_high <= 1'b0;
                    r_line <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (o_bit_done) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ws2812_strand_driver.sv
// WS2812 strand driver: LED index walk, colour prefetch and NRZ framing with latch gap.
// Optional WS_DRIVER_STATS_EN adds frames_sent and underrun_sticky outputs.
module ws2812_strand_driver
    import led_pkg::*;
#(
    parameter int NUM_LEDS     = 20,
    parameter int COLOR_WIDTH  = DEF_COLOR_WIDTH,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T0L_CYCLES   = DEF_T0L_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int T1L_CYCLES   = DEF_T1L_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    localparam int IDX_WIDTH   = $clog2(NUM_LEDS + 1)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    output logic [IDX_WIDTH-1:0]   next_led_request,
    output logic                   request_valid,
    input  logic [COLOR_WIDTH-1:0] green_in,
    input  logic [COLOR_WIDTH-1:0] red_in,
    input  logic [COLOR_WIDTH-1:0] blue_in,
    input  logic                   color_valid,
    output logic                   strand_out,
    output logic                   frame_done
`ifdef WS_DRIVER_STATS_EN
    ,
    output logic [15:0]            frames_sent,
    output logic                   underrun_sticky
`endif
);

    localparam int WORD_BITS     = 3 * COLOR_WIDTH;
    localparam int BIT_IDX_WIDTH = $clog2(WORD_BITS);
    localparam int CNT_WIDTH     = counter_width(T0H_CYCLES, T0L_CYCLES, T1H_CYCLES,
                                                 T1L_CYCLES, RESET_CYCLES);

    drv_state_t               r_state;
    drv_state_t               w_next_state;
    logic [CNT_WIDTH-1:0]     r_latch_cnt;
    logic                     r_prime_armed;
    logic                     r_fetch_armed;
    logic                     r_hold_valid;
    logic [WORD_BITS-1:0]     r_shift;
    logic [WORD_BITS-1:0]     r_hold;
    logic [IDX_WIDTH-1:0]     r_led;
    logic [BIT_IDX_WIDTH-1:0] r_bit_idx;
    logic [IDX_WIDTH-1:0]     r_req;
    logic                     r_req_valid;
    logic                     r_frame_done;

    logic [WORD_BITS-1:0]     w_color;
    logic [WORD_BITS-1:0]     w_word;
    logic [IDX_WIDTH-1:0]     w_start_led;
    logic                     w_bit_done;
    logic                     w_line;
    logic                     w_prime_capture;
    logic                     w_hold_capture;
    logic                     w_led_end;
    logic                     w_last_led;
    logic                     w_frame_end;
    logic                     w_led_start;
    logic                     w_start;

    assign w_color         = {green_in, red_in, blue_in};
    assign w_prime_capture = (r_state == PRIME) && r_prime_armed && color_valid;
    assign w_led_end       = (r_state == SEND) && w_bit_done
                             && (r_bit_idx == BIT_IDX_WIDTH'(WORD_BITS - 1));
    assign w_last_led      = (r_led == IDX_WIDTH'(NUM_LEDS - 1));
    assign w_frame_end     = w_led_end && w_last_led;
    assign w_led_start     = w_prime_capture || (w_led_end && !w_last_led);
    assign w_start         = w_led_start || ((r_state == SEND) && w_bit_done && !w_led_end);
    // The first cycle of each LED still shows the previous request's colour, so skip it.
    assign w_hold_capture  = (r_state == SEND) && r_fetch_armed && r_req_valid
                             && !r_hold_valid && color_valid;
    assign w_start_led     = w_prime_capture ? '0 : r_led + 1'b1;

    // Word whose MSB is the bit starting this cycle; an underrun substitutes all zeros.
    always_comb begin
        w_word = r_shift;
        if (w_prime_capture) begin
            w_word = w_color;
        end else if (w_led_end) begin
            if (r_hold_valid)        w_word = r_hold;
            else if (w_hold_capture) w_word = w_color;
            else                     w_word = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= LATCH;
        else        r_state <= w_next_state;
    end

    // NOTE: next state is given a default before the case so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LATCH:   if (r_latch_cnt == CNT_WIDTH'(RESET_CYCLES - 1)) w_next_state = PRIME;
            PRIME:   if (w_prime_capture) w_next_state = SEND;
            SEND:    if (w_frame_end) w_next_state = LATCH;
            default: w_next_state = LATCH;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_latch_cnt   <= '0;
            r_prime_armed <= 1'b0;
            r_fetch_armed <= 1'b0;
            r_hold_valid  <= 1'b0;
            r_led         <= '0;
            r_bit_idx     <= '0;
            r_req         <= IDX_WIDTH'(NUM_LEDS);
            r_req_valid   <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done  <= w_frame_end;
            r_prime_armed <= (r_state == PRIME);
            r_latch_cnt   <= (r_state == LATCH && w_next_state == LATCH) ? r_latch_cnt + 1'b1 : '0;
            if (r_state == LATCH && w_next_state == PRIME) begin
                r_req       <= '0;
                r_req_valid <= 1'b1;
            end
            if (w_start) r_bit_idx <= w_led_start ? '0 : r_bit_idx + 1'b1;
            if (w_led_start) begin
                r_led         <= w_start_led;
                r_hold_valid  <= 1'b0;
                r_fetch_armed <= 1'b0;
                if (w_start_led == IDX_WIDTH'(NUM_LEDS - 1)) begin
                    r_req       <= IDX_WIDTH'(NUM_LEDS);
                    r_req_valid <= 1'b0;
                end else begin
                    r_req       <= w_start_led + 1'b1;
                    r_req_valid <= 1'b1;
                end
            end else begin
                r_fetch_armed <= (r_state == SEND);
                if (w_hold_capture) r_hold_valid <= 1'b1;
            end
        end
    end

    // NOTE: payload registers carry no reset; they are only consumed behind valid/state qualifiers.
    always_ff @(posedge clk_in) begin
        if (w_start)                       r_shift <= w_word << 1;
        if (w_hold_capture && !w_led_start) r_hold <= w_color;
    end

    ws2812_bit_encoder #(
        .CNT_WIDTH  (CNT_WIDTH),
        .T0H_CYCLES (T0H_CYCLES),
        .T0L_CYCLES (T0L_CYCLES),
        .T1H_CYCLES (T1H_CYCLES),
        .T1L_CYCLES (T1L_CYCLES)
    ) u_encoder (
        .i_clk      (clk_in),
        .i_rst      (rst_in),
        .i_start    (w_start),
        .i_bit      (w_word[WORD_BITS-1]),
        .o_line     (w_line),
        .o_bit_done (w_bit_done)
    );

    assign strand_out       = w_line;
    assign frame_done       = r_frame_done;
    assign next_led_request = r_req;
    assign request_valid    = r_req_valid;

`ifdef WS_DRIVER_STATS_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            frames_sent     <= '0;
            underrun_sticky <= 1'b0;
        end else begin
            if (w_frame_end) frames_sent <= frames_sent + 1'b1;
            if (w_led_end && !w_last_led && !r_hold_valid && !w_hold_capture)
                underrun_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ws2812_strand_driver.sv
// Self-checking bench: a waveform model built from LED colours is compared against the DUT each cycle.
module tb_ws2812_strand_driver;
    import led_pkg::*;

    localparam int N   = 3;
    localparam int CW  = 8;
    localparam int T0H = 2;
    localparam int T0L = 4;
    localparam int T1H = 4;
    localparam int T1L = 2;
    localparam int RST = 10;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic [1:0]    next_led_request;
    logic          request_valid;
    logic [CW-1:0] green_in = '0;
    logic [CW-1:0] red_in = '0;
    logic [CW-1:0] blue_in = '0;
    logic          color_valid = 1'b0;
    logic          strand_out;
    logic          frame_done;
`ifdef WS_DRIVER_STATS_EN
    logic [15:0]   frames_sent;
    logic          underrun_sticky;
`endif

    ws2812_strand_driver #(
        .NUM_LEDS(N), .COLOR_WIDTH(CW), .T0H_CYCLES(T0H), .T0L_CYCLES(T0L),
        .T1H_CYCLES(T1H), .T1L_CYCLES(T1L), .RESET_CYCLES(RST)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .next_led_request (next_led_request),
        .request_valid    (request_valid),
        .green_in         (green_in),
        .red_in           (red_in),
        .blue_in          (blue_in),
        .color_valid      (color_valid),
        .strand_out       (strand_out),
        .frame_done       (frame_done)
`ifdef WS_DRIVER_STATS_EN
        ,
        .frames_sent      (frames_sent),
        .underrun_sticky  (underrun_sticky)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic line;
        int   req;
        logic rv;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    grb_t col_tab[4];
    bit   wh_tab[4];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic line, input int req, input logic rv, input logic done);
        exp_t e;
        e.line = line;
        e.req  = req;
        e.rv   = rv;
        e.done = done;
        exp_q.push_back(e);
    endtask

    // One frame: latch gap, two-cycle prime with the stub's latency, then 24 bits per LED.
    task automatic build_frame(input bit first);
        logic [23:0] word;
        int nreq;
        int h;
        int l;
        for (int k = 0; k < RST; k++) push(1'b0, N, 1'b0, (k == 0) && !first);
        for (int k = 0; k < 2; k++) push(1'b0, 0, 1'b1, 1'b0);
        for (int led = 0; led < N; led++) begin
            if (led > 0 && wh_tab[led]) word = '0;
            else                        word = col_tab[led];
            nreq = (led + 1 < N) ? led + 1 : N;
            for (int b = 23; b >= 0; b--) begin
                h = word[b] ? T1H : T0H;
                l = word[b] ? T1L : T0L;
                for (int c = 0; c < h; c++) push(1'b1, nreq, nreq < N, 1'b0);
                for (int c = 0; c < l; c++) push(1'b0, nreq, nreq < N, 1'b0);
            end
        end
    endtask

    function automatic int count_high();
        int c = 0;
        foreach (exp_q[i]) if (exp_q[i].line) c++;
        return c;
    endfunction

    task automatic compare(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                check($sformatf("model_empty@%0d", cyc), 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("line@%0d", cyc), strand_out, e.line);
                check($sformatf("req@%0d", cyc), next_led_request, e.req);
                check($sformatf("req_valid@%0d", cyc), request_valid, e.rv);
                check($sformatf("frame_done@%0d", cyc), frame_done, e.done);
            end
            cyc++;
            @(negedge clk_in);
        end
    endtask

    // Pattern stub: answers each request one registered cycle later; invalid data is junk.
    initial begin : stub
        int prev_req;
        bit prev_rv;
        prev_req = N;
        prev_rv  = 1'b0;
        forever begin
            @(negedge clk_in);
            if (prev_rv && !wh_tab[prev_req]) begin
                color_valid = 1'b1;
                green_in    = col_tab[prev_req].g;
                red_in      = col_tab[prev_req].r;
                blue_in     = col_tab[prev_req].b;
            end else begin
                color_valid = 1'b0;
                green_in    = 8'hEE;
                red_in      = 8'hEE;
                blue_in     = 8'hEE;
            end
            prev_req = int'(next_led_request);
            prev_rv  = request_valid;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin : main
        for (int i = 0; i < 4; i++) begin
            col_tab[i] = '0;
            wh_tab[i]  = 1'b0;
        end
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;

        // Frame 1: all-zero LEDs straight out of reset.
        cyc = 0;
        build_frame(1'b1);
        check("model_frame_len", exp_q.size(), 444);
        check("reset_req_idle", next_led_request, 3);
        check("reset_line_low", strand_out, 0);
        compare(12);
        check("first_send_high", strand_out, 1);
        compare(432);
        check("frame_done_at_444", frame_done, 1);

        // Frame 2: LED1 = G 0x80, R 0x01, B 0x00.
        col_tab[1] = 24'h800100;
        cyc = 0;
        build_frame(1'b0);
        check("model_high_cycles", count_high(), 148);
        compare(444);

        // Frame 3: LED2 colour withheld, so LED2 must go out as zeros.
        col_tab[0] = 24'hFFFFFF;
        col_tab[1] = 24'h0F0F0F;
        col_tab[2] = 24'hAA55AA;
        wh_tab[2]  = 1'b1;
        cyc = 0;
        build_frame(1'b0);
        compare(444);
`ifdef WS_DRIVER_STATS_EN
        check("frames_sent_3", frames_sent, 3);
        check("underrun_sticky_set", underrun_sticky, 1);
`endif

        // Frame 4: reset lands in the high phase of LED1 bit 1.
        wh_tab[2]  = 1'b0;
        col_tab[0] = 24'h123456;
        col_tab[1] = 24'hC35AF0;
        col_tab[2] = 24'h00FF81;
        cyc = 0;
        build_frame(1'b0);
        compare(164);
        check("pre_reset_line_high", strand_out, 1);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check("midreset_line_low", strand_out, 0);
        check("midreset_req_idle", next_led_request, 3);
        check("midreset_req_valid", request_valid, 0);
        check("midreset_no_done", frame_done, 0);
`ifdef WS_DRIVER_STATS_EN
        check("midreset_frames_clr", frames_sent, 0);
        check("midreset_sticky_clr", underrun_sticky, 0);
`endif
        exp_q.delete();
        cyc = 0;
        build_frame(1'b1);
        compare(444);
        build_frame(1'b0);
        compare(1);
`ifdef WS_DRIVER_STATS_EN
        check("frames_sent_after_reset", frames_sent, 1);
        check("sticky_stays_clear", underrun_sticky, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
